// File: rtl/iop_rr_arbiter.sv
// ---------------------------------------------------------------------------
// iop_rr_arbiter
//
// Shares one IOP slave port between NUM_REQ (2..4) requesters using
// round-robin arbitration. Every access walks IDLE -> ACCESS -> RESP.
// RESP re-arbitrates, so pending requests are served one every two cycles.
//
// Optional feature macro: IOP_ARB_LOCK_EN
//   When defined, a requester that is latched with req_lock high keeps the
//   bus in the following RESP re-arbitration for as long as both req and
//   req_lock stay high. While a lock is held the pointer does not advance.
//   When undefined, req_lock is ignored.
//
// Ports
//   HCLK, HRESET        clock, asynchronous active-high reset
//   req/req_write       per-requester request level and direction
//   req_addr/size/wdata packed per-requester fields (12/2/32 bits each)
//   req_lock            per-requester bus-lock request
//   gnt                 one-hot pulse in the ACCESS cycle of the winner
//   done                one-hot pulse in the RESP cycle (rdata valid on reads)
//   rdata               IORDATA captured at the end of the last read ACCESS
//   IOSEL/IOTRANS       high only during ACCESS
//   IOADDR/IOWRITE/IOSIZE/IOWDATA  registered address phase, held while idle
//   IORDATA             slave read data
//   dbg_state           current FSM state (0 IDLE, 1 ACCESS, 2 RESP)
//
// Handshake: a requester raises req with its fields and holds all of them
// stable until it sees its gnt bit. The req level in the cycle after gnt
// (the RESP cycle) counts as a fresh request. Completion is signalled by
// the matching done bit one cycle after gnt.
// ---------------------------------------------------------------------------
module iop_rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic                    HCLK,
  input  logic                    HRESET,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [NUM_REQ-1:0]      req_write,
  input  logic [12*NUM_REQ-1:0]   req_addr,
  input  logic [2*NUM_REQ-1:0]    req_size,
  input  logic [32*NUM_REQ-1:0]   req_wdata,
  input  logic [NUM_REQ-1:0]      req_lock,
  output logic [NUM_REQ-1:0]      gnt,
  output logic [NUM_REQ-1:0]      done,
  output logic [31:0]             rdata,
  output logic                    IOSEL,
  output logic                    IOTRANS,
  output logic [11:0]             IOADDR,
  output logic                    IOWRITE,
  output logic [1:0]              IOSIZE,
  output logic [31:0]             IOWDATA,
  input  logic [31:0]             IORDATA,
  output logic [1:0]              dbg_state
);

  localparam int PTR_W = (NUM_REQ > 2) ? 2 : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;     // last latched winner
  logic [PTR_W-1:0]     win_q, win_d;     // requester owning the current access
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic [31:0]          rdata_q, rdata_d;
  logic                 sel_q, sel_d;
  logic [11:0]          addr_q, addr_d;
  logic                 write_q, write_d;
  logic [1:0]           size_q, size_d;
  logic [31:0]          wdata_q, wdata_d;

  logic [PTR_W-1:0]     rr_win;
  logic                 rr_found;
  logic [PTR_W-1:0]     cand;
  logic                 keep_lock;
  logic [PTR_W-1:0]     pick;
  logic                 pick_valid;
  logic                 latch;

`ifdef IOP_ARB_LOCK_EN
  logic lock_q, lock_d;
`else
  logic unused_req_lock;
  assign unused_req_lock = ^req_lock;
`endif

  // Round-robin search: first requester after the pointer, wrapping.
  always_comb begin
    rr_found = 1'b0;
    rr_win   = ptr_q;
    cand     = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = PTR_W'((int'(ptr_q) + i) % NUM_REQ);
      if (!rr_found && req[cand]) begin
        rr_found = 1'b1;
        rr_win   = cand;
      end
    end
  end

  // A held lock overrides the round-robin choice in RESP only.
  always_comb begin
`ifdef IOP_ARB_LOCK_EN
    keep_lock = (state_q == ST_RESP) && lock_q && req[win_q] && req_lock[win_q];
`else
    keep_lock = 1'b0;
`endif
    pick       = keep_lock ? win_q : rr_win;
    pick_valid = keep_lock | rr_found;
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    gnt_d   = '0;
    done_d  = '0;
    rdata_d = rdata_q;
    sel_d   = 1'b0;
    addr_d  = addr_q;
    write_d = write_q;
    size_d  = size_q;
    wdata_d = wdata_q;
    latch   = 1'b0;
`ifdef IOP_ARB_LOCK_EN
    lock_d  = lock_q;
`endif

    case (state_q)
      ST_IDLE: begin
        latch = pick_valid;
      end
      ST_ACCESS: begin
        for (int j = 0; j < NUM_REQ; j++) begin
          done_d[j] = (win_q == PTR_W'(j));
        end
        // Writes leave the last read data visible.
        if (!write_q) begin
          rdata_d = IORDATA;
        end
        state_d = ST_RESP;
      end
      ST_RESP: begin
        latch = pick_valid;
        if (!pick_valid) begin
          state_d = ST_IDLE;
`ifdef IOP_ARB_LOCK_EN
          lock_d  = 1'b0;
`endif
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (latch) begin
      state_d = ST_ACCESS;
      sel_d   = 1'b1;
      win_d   = pick;
      for (int j = 0; j < NUM_REQ; j++) begin
        if (pick == PTR_W'(j)) begin
          gnt_d[j] = 1'b1;
          addr_d   = req_addr[j*12 +: 12];
          write_d  = req_write[j];
          size_d   = req_size[j*2 +: 2];
          wdata_d  = req_wdata[j*32 +: 32];
        end
      end
`ifdef IOP_ARB_LOCK_EN
      lock_d = req_lock[pick];
      if (!req_lock[pick]) begin
        ptr_d = pick;
      end
`else
      ptr_d = pick;
`endif
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q <= ST_IDLE;
      ptr_q   <= PTR_W'(NUM_REQ - 1);
      win_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      rdata_q <= '0;
      sel_q   <= 1'b0;
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= '0;
      wdata_q <= '0;
`ifdef IOP_ARB_LOCK_EN
      lock_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      size_q  <= size_d;
      wdata_q <= wdata_d;
`ifdef IOP_ARB_LOCK_EN
      lock_q  <= lock_d;
`endif
    end
  end

  assign gnt       = gnt_q;
  assign done      = done_q;
  assign rdata     = rdata_q;
  assign IOSEL     = sel_q;
  assign IOTRANS   = sel_q;
  assign IOADDR    = addr_q;
  assign IOWRITE   = write_q;
  assign IOSIZE    = size_q;
  assign IOWDATA   = wdata_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_iop_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_iop_rr_arbiter
//
// Bench for iop_rr_arbiter with four requesters. The IOP slave returns
// rd_base ^ IOADDR while selected and a poison value otherwise, so rdata
// reveals both the address and the capture cycle. Every access pushes
// {winner, rdata} into exp_q; the monitor pops an entry on each done pulse.
// ---------------------------------------------------------------------------
module tb_iop_rr_arbiter;
  localparam int N = 4;
  localparam logic [47:0]  ADDR_V  = {12'h30C, 12'h208, 12'h010, 12'h004};
  localparam logic [127:0] WDATA_V = {32'h3333_0003, 32'h2222_0002,
                                      32'hDEAD_BEEF, 32'h1111_0001};
  // requester sizes: r0=0, r1=2, r2=1, r3=3
  localparam logic [7:0]   SIZE_V  = 8'hD8;

  logic            HCLK = 1'b0;
  logic            HRESET = 1'b1;
  logic [N-1:0]    req = '0;
  logic [N-1:0]    req_write = '0;
  logic [12*N-1:0] req_addr = ADDR_V;
  logic [2*N-1:0]  req_size = SIZE_V;
  logic [32*N-1:0] req_wdata = WDATA_V;
  logic [N-1:0]    req_lock = '0;
  logic [N-1:0]    gnt;
  logic [N-1:0]    done;
  logic [31:0]     rdata;
  logic            IOSEL;
  logic            IOTRANS;
  logic [11:0]     IOADDR;
  logic            IOWRITE;
  logic [1:0]      IOSIZE;
  logic [31:0]     IOWDATA;
  logic [31:0]     IORDATA;
  logic [1:0]      dbg_state;
  logic [31:0]     rd_base = '0;

  int checks = 0;
  int errors = 0;
  logic [33:0] exp_q[$];

  iop_rr_arbiter #(.NUM_REQ(N)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .req(req), .req_write(req_write),
    .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
    .req_lock(req_lock), .gnt(gnt), .done(done), .rdata(rdata),
    .IOSEL(IOSEL), .IOTRANS(IOTRANS), .IOADDR(IOADDR), .IOWRITE(IOWRITE),
    .IOSIZE(IOSIZE), .IOWDATA(IOWDATA), .IORDATA(IORDATA),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / slave model ----------------
  always #5 HCLK = ~HCLK;
  assign IORDATA = IOSEL ? (rd_base ^ {20'd0, IOADDR}) : 32'hBAD0_0000;

  // ---------------- helpers ----------------
  function automatic logic [11:0] addr_of(input int i);
    logic [47:0] a;
    a = ADDR_V;
    return a[i*12 +: 12];
  endfunction

  function automatic logic [31:0] wdata_of(input int i);
    logic [127:0] w;
    w = WDATA_V;
    return w[i*32 +: 32];
  endfunction

  function automatic logic [1:0] size_of(input int i);
    logic [7:0] s;
    s = SIZE_V;
    return s[i*2 +: 2];
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge HCLK) begin
    if (!HRESET) begin
      if (gnt != '0 && done != '0) begin
        check("gnt_done_overlap", {28'd0, gnt & done}, 32'd0);
      end
      if (done != '0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", {28'd0, done}, 32'd0);
        end else begin
          logic [33:0] e;
          e = exp_q.pop_front();
          check("done_onehot", {28'd0, done}, 32'd1 << e[33:32]);
          check("rdata", rdata, e[31:0]);
        end
      end
    end
  end

  // ---------------- table-driven single accesses ----------------
  typedef struct {
    logic [3:0]  req;
    logic [3:0]  wr;
    logic [31:0] rd_base;
    int          exp_w;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[8];

  task automatic run_vec(input vec_t v, input int n);
    logic [11:0] hold_addr;
    logic [31:0] hold_wdata;
    req_write = v.wr;
    rd_base   = v.rd_base;
    req       = v.req;
    exp_q.push_back({2'(v.exp_w), v.exp_rdata});
    @(posedge HCLK); #1;
    check($sformatf("v%0d gnt", n), {28'd0, gnt}, 32'd1 << v.exp_w);
    check($sformatf("v%0d state_access", n), {30'd0, dbg_state}, 32'd1);
    check($sformatf("v%0d iosel", n), {30'd0, IOSEL, IOTRANS}, 32'd3);
    check($sformatf("v%0d ioaddr", n), {20'd0, IOADDR}, {20'd0, addr_of(v.exp_w)});
    check($sformatf("v%0d iowrite", n), {31'd0, IOWRITE}, {31'd0, v.wr[v.exp_w]});
    check($sformatf("v%0d iosize", n), {30'd0, IOSIZE}, {30'd0, size_of(v.exp_w)});
    check($sformatf("v%0d iowdata", n), IOWDATA, wdata_of(v.exp_w));
    hold_addr  = addr_of(v.exp_w);
    hold_wdata = wdata_of(v.exp_w);
    req = '0;
    @(posedge HCLK); #1;
    check($sformatf("v%0d resp_iosel", n), {30'd0, IOSEL, IOTRANS}, 32'd0);
    check($sformatf("v%0d resp_gnt", n), {28'd0, gnt}, 32'd0);
    @(posedge HCLK); #1;
    check($sformatf("v%0d idle_state", n), {30'd0, dbg_state}, 32'd0);
    check($sformatf("v%0d idle_addr_hold", n), {20'd0, IOADDR}, {20'd0, hold_addr});
    check($sformatf("v%0d idle_wdata_hold", n), IOWDATA, hold_wdata);
  endtask

  // Run alternating ACCESS/RESP with a fixed request pattern held high;
  // exp_order gives the expected winner of each access.
  task automatic run_stream(input string name, input int n_acc,
                            input int exp_order[8]);
    for (int k = 0; k < 2*n_acc; k++) begin
      @(posedge HCLK); #1;
      if (k % 2 == 0) begin
        check($sformatf("%s gnt%0d", name, k/2), {28'd0, gnt},
              32'd1 << exp_order[k/2]);
        check($sformatf("%s iosel%0d", name, k/2), {31'd0, IOSEL}, 32'd1);
        exp_q.push_back({2'(exp_order[k/2]),
                         rd_base ^ {20'd0, addr_of(exp_order[k/2])}});
      end else begin
        check($sformatf("%s gap%0d", name, k/2), {27'd0, IOSEL, gnt}, 32'd0);
      end
      if (k == 2*n_acc - 1) begin
        req      = '0;
        req_lock = '0;
      end
    end
    repeat (2) @(posedge HCLK);
    #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int rr_order[8];
    int lk_order[8];

    // pointer tracked by hand: starts at 3
    vecs[0] = '{4'b0001, 4'b0000, 32'hA5A5_0005, 0, 32'hA5A5_0001};
    vecs[1] = '{4'b0010, 4'b0010, 32'h1234_5678, 1, 32'hA5A5_0001};
    vecs[2] = '{4'b1111, 4'b0000, 32'h5000_0000, 2, 32'h5000_0208};
    vecs[3] = '{4'b1001, 4'b0000, 32'h6000_0000, 3, 32'h6000_030C};
    vecs[4] = '{4'b1100, 4'b0100, 32'h6666_6666, 2, 32'h6000_030C};
    vecs[5] = '{4'b0101, 4'b0000, 32'h7000_0000, 0, 32'h7000_0004};
    vecs[6] = '{4'b1000, 4'b0000, 32'h8000_0000, 3, 32'h8000_030C};
    vecs[7] = '{4'b0110, 4'b0000, 32'h9000_0000, 1, 32'h9000_0010};

    rr_order = '{0, 1, 2, 3, 0, 1, 2, 3};
`ifdef IOP_ARB_LOCK_EN
    lk_order = '{0, 0, 0, 0, 0, 0, 0, 0};
`else
    lk_order = '{0, 1, 0, 1, 0, 1, 0, 1};
`endif

    // reset values
    #12;
    check("rst gnt_done", {24'd0, gnt, done}, 32'd0);
    check("rst rdata", rdata, 32'd0);
    check("rst iosel", {30'd0, IOSEL, IOTRANS}, 32'd0);
    check("rst ioaddr_write_size", {17'd0, IOADDR, IOWRITE, IOSIZE}, 32'd0);
    check("rst iowdata", IOWDATA, 32'd0);
    check("rst state", {30'd0, dbg_state}, 32'd0);
    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    HRESET = 1'b0;
    @(posedge HCLK); #1;

    for (int n = 0; n < 8; n++) begin
      run_vec(vecs[n], n);
    end

    // reset in ACCESS: everything clears at once, no done follows
    req_write = '0;
    rd_base   = 32'hEEEE_0000;
    req       = 4'b0100;
    @(posedge HCLK); #1;
    check("abort gnt", {28'd0, gnt}, 32'b0100);
    HRESET = 1'b1;
    req    = '0;
    #1;
    check("abort gnt_done", {24'd0, gnt, done}, 32'd0);
    check("abort iosel", {30'd0, IOSEL, IOTRANS}, 32'd0);
    check("abort ioaddr", {20'd0, IOADDR}, 32'd0);
    check("abort iowdata", IOWDATA, 32'd0);
    check("abort rdata", rdata, 32'd0);
    check("abort state", {30'd0, dbg_state}, 32'd0);
    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    HRESET = 1'b0;
    @(posedge HCLK); #1;

    // all four requesting: pointer restarts at requester 0
    rd_base = 32'hC000_0000;
    req     = 4'b1111;
    run_stream("rr", 8, rr_order);

    // lock request on requester 0 (ignored unless the lock build)
    rd_base  = 32'hD000_0000;
    req      = 4'b0011;
    req_lock = 4'b0001;
    run_stream("lock", 4, lk_order);

    repeat (3) @(posedge HCLK);
    #1;
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d",
             checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
